// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake and presents the fetched word to decode until it is consumed.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_fetch_en,
   input  logic        i_pc_sel,
   input  logic [31:0] i_pc_immed,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr,
   output logic        o_instr_valid,
   output logic [31:0] o_pc,
   output logic        o_fetch_err
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_ERR
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_instr;
   logic             r_instr_valid;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [31:0]      w_pc_offset;
   logic [31:0]      w_pc_next;
   logic             w_unused;

   // The word offset's top two bits fall off the left end of the <<2.
   assign w_pc_offset = i_pc_sel ? {i_pc_immed[29:0], 2'b00} : 32'd0;
   assign w_pc_next   = r_pc + 32'd4 + w_pc_offset;
   assign w_unused    = ^i_pc_immed[31:30];

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (i_fetch_en) w_next_state = S_FETCH;
         S_FETCH: begin
            if (i_imem_ack)                  w_next_state = S_HOLD;
            else if (r_wait_cnt == CNT_MAX)  w_next_state = S_ERR;
         end
         S_HOLD:  if (i_fetch_en) w_next_state = S_FETCH;
         S_ERR:   w_next_state = S_ERR;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: state uses <= and an async reset so imem_req drops the moment reset rises.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_instr_valid <= 1'b0;
         r_wait_cnt    <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (i_imem_ack) begin
                  r_instr       <= i_imem_rdata;
                  r_instr_valid <= 1'b1;
                  r_wait_cnt    <= '0;
               end else if (r_wait_cnt == CNT_MAX) begin
                  r_wait_cnt    <= '0;
               end else begin
                  r_wait_cnt    <= r_wait_cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (i_fetch_en) begin
                  r_pc          <= w_pc_next;
                  r_instr_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_imem_req    = (r_state == S_FETCH);
   assign o_imem_addr   = r_pc;
   assign o_pc          = r_pc;
   assign o_instr       = r_instr;
   assign o_instr_valid = r_instr_valid;
   assign o_fetch_err   = (r_state == S_ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_fetch_unit;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_fetch_en = 1'b0;
   logic        i_pc_sel = 1'b0;
   logic [31:0] i_pc_immed = 32'd0;
   logic        i_imem_ack = 1'b0;
   logic [31:0] i_imem_rdata;

   logic        o_imem_req, w2_imem_req;
   logic [31:0] o_imem_addr, w2_imem_addr;
   logic [31:0] o_instr, w2_instr;
   logic        o_instr_valid, w2_instr_valid;
   logic [31:0] o_pc, w2_pc;
   logic        o_fetch_err, w2_fetch_err;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   // Model state: what the fetch stage must be showing after each edge.
   logic [31:0] m_pc = 32'd0;
   logic [31:0] m_instr = 32'd0;
   bit          m_valid = 1'b0;
   bit          m_req = 1'b0;
   bit          m_err = 1'b0;
   int          m_waited = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      return {addr[15:0], ~addr[15:0]};
   endfunction

   // Memory contents are a fixed function of the address being read.
   assign i_imem_rdata = word_at(o_imem_addr);

   fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_fetch_en(i_fetch_en),
      .i_pc_sel(i_pc_sel), .i_pc_immed(i_pc_immed),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
      .o_instr(o_instr), .o_instr_valid(o_instr_valid),
      .o_pc(o_pc), .o_fetch_err(o_fetch_err)
   );

   // Same stimulus, PC starting one word below zero: its PC must always trail by 4.
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(TIMEOUT)) dut_wrap (
      .i_clk(clk), .i_reset(i_reset), .i_fetch_en(i_fetch_en),
      .i_pc_sel(i_pc_sel), .i_pc_immed(i_pc_immed),
      .o_imem_req(w2_imem_req), .o_imem_addr(w2_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
      .o_instr(w2_instr), .o_instr_valid(w2_instr_valid),
      .o_pc(w2_pc), .o_fetch_err(w2_fetch_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         m_pc <= 32'd0; m_instr <= 32'd0; m_valid <= 1'b0;
         m_req <= 1'b0; m_err <= 1'b0; m_waited <= 0;
      end else if (m_err) begin
         m_err <= 1'b1;
      end else if (m_req) begin
         if (i_imem_ack) begin
            m_instr <= word_at(m_pc); m_valid <= 1'b1; m_req <= 1'b0; m_waited <= 0;
         end else begin
            m_waited <= m_waited + 1;
            if (m_waited + 1 == TIMEOUT) begin m_err <= 1'b1; m_req <= 1'b0; end
         end
      end else if (i_fetch_en) begin
         if (m_valid) begin
            m_pc <= m_pc + 32'd4 + (i_pc_sel ? i_pc_immed * 32'd4 : 32'd0);
            m_valid <= 1'b0;
         end
         m_req <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("req",        o_imem_req,     m_req);
         check("addr",       o_imem_addr,    m_pc);
         check("pc",         o_pc,           m_pc);
         check("valid",      o_instr_valid,  m_valid);
         check("instr",      o_instr,        m_instr);
         check("err",        o_fetch_err,    m_err);
         check("wrap_pc",    w2_pc,          m_pc - 32'd4);
         check("wrap_addr",  w2_imem_addr,   m_pc - 32'd4);
         check("wrap_req",   w2_imem_req,    m_req);
         check("wrap_valid", w2_instr_valid, m_valid);
         check("wrap_instr", w2_instr,       m_instr);
         check("wrap_err",   w2_fetch_err,   m_err);
      end
   end

   task automatic drive(input logic fe, input logic sel, input logic [31:0] imm, input logic ack);
      i_fetch_en = fe; i_pc_sel = sel; i_pc_immed = imm; i_imem_ack = ack;
      @(posedge clk); #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2 i_reset = 1'b0;
      cmp_en = 1'b1;
      check("rst_req",   o_imem_req,    32'd0);
      check("rst_pc",    o_pc,          32'd0);
      check("rst_instr", o_instr,       32'd0);
      check("rst_valid", o_instr_valid, 32'd0);
      check("rst_err",   o_fetch_err,   32'd0);
      check("rst_wrap",  w2_pc,         32'hFFFF_FFFC);

      // Zero-wait sequential fetches with fetch_en held high.
      drive(1, 0, 0, 1);
      check("seq_addr0", o_imem_addr, 32'h0);
      check("seq_req0",  o_imem_req,  32'd1);
      drive(1, 0, 0, 1);
      check("seq_instr0", o_instr, 32'h0000_FFFF);
      check("seq_valid0", o_instr_valid, 32'd1);
      drive(1, 0, 0, 1);
      check("seq_addr4",  o_imem_addr, 32'h4);
      check("seq_valid_low", o_instr_valid, 32'd0);
      check("wrap_to_0",  w2_imem_addr, 32'h0);
      drive(1, 0, 0, 1);
      check("seq_instr4", o_instr, 32'h0004_FFFB);
      drive(1, 0, 0, 1);
      check("seq_addr8",  o_imem_addr, 32'h8);
      drive(1, 0, 0, 1);
      check("seq_instr8", o_instr, 32'h0008_FFF7);

      // Backward then forward branch from pc=8.
      drive(1, 1, 32'hFFFF_FFFE, 0);
      check("br_back", o_imem_addr, 32'h4);
      drive(0, 0, 0, 1);
      drive(1, 0, 0, 0);
      check("br_seq8", o_imem_addr, 32'h8);
      drive(0, 0, 0, 1);
      drive(1, 1, 32'h3, 0);
      check("br_fwd", o_imem_addr, 32'h18);

      // Three wait states before the ack.
      repeat (3) drive(0, 0, 0, 0);
      check("ws_req",   o_imem_req,  32'd1);
      check("ws_addr",  o_imem_addr, 32'h18);
      check("ws_valid", o_instr_valid, 32'd0);
      drive(0, 0, 0, 1);
      check("ws_valid_rise", o_instr_valid, 32'd1);
      check("ws_instr", o_instr, 32'h0018_FFE7);
      check("ws_err",   o_fetch_err, 32'd0);
      drive(0, 0, 0, 1);
      check("hold_ack_ignored", o_instr_valid, 32'd1);

      // Ack on the last permitted FETCH cycle is still accepted.
      drive(1, 0, 0, 0);
      repeat (TIMEOUT - 1) drive(0, 0, 0, 0);
      check("edge_err", o_fetch_err, 32'd0);
      check("edge_req", o_imem_req,  32'd1);
      drive(0, 0, 0, 1);
      check("edge_valid", o_instr_valid, 32'd1);
      check("edge_instr", o_instr, 32'h001C_FFE3);

      // No ack at all: timeout on the TIMEOUT-th cycle.
      drive(1, 0, 0, 0);
      repeat (TIMEOUT - 1) drive(0, 0, 0, 0);
      check("to_not_yet", o_fetch_err, 32'd0);
      drive(0, 0, 0, 0);
      check("to_err", o_fetch_err, 32'd1);
      check("to_req", o_imem_req,  32'd0);
      repeat (3) drive(1, 0, 0, 1);
      check("err_sticky", o_fetch_err,   32'd1);
      check("err_valid",  o_instr_valid, 32'd0);
      check("err_pc",     o_pc,          32'h20);

      // Reset clears the error.
      i_reset = 1'b1; #1;
      check("err_clear", o_fetch_err, 32'd0);
      check("err_clear_pc", o_pc, 32'h0);
      #1 i_reset = 1'b0;

      // Reset in the middle of a handshake, then a late ack.
      drive(1, 0, 0, 0);
      repeat (2) drive(0, 0, 0, 0);
      check("mid_req_before", o_imem_req, 32'd1);
      i_reset = 1'b1; #1;
      check("mid_req_async", o_imem_req, 32'd0);
      #1 i_reset = 1'b0;
      drive(0, 0, 0, 1);
      check("late_ack_valid", o_instr_valid, 32'd0);
      check("late_ack_req",   o_imem_req,    32'd0);
      drive(1, 0, 0, 1);
      drive(0, 0, 0, 1);
      check("restart_instr", o_instr, 32'h0000_FFFF);
      check("restart_valid", o_instr_valid, 32'd1);

      @(posedge clk); #2;
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that feeds the decode stage. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and registers the returned word as `instr` with a valid flag for decode and control. Computes the next PC as either PC+4 or the branch target PC+4+(immed<<2), with a bounded-wait timeout on the memory handshake.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset; must be word-aligned.
- `TIMEOUT`, 16: maximum FETCH cycles to wait for `imem_ack` before error (≥2).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_en`  in  1  start the first fetch (IDLE) or consume the current instruction and advance (HOLD).
- `pc_sel`  in  1  0: next PC = PC+4; 1: next PC = PC+4+(pc_immed<<2).
- `pc_immed`  in  32  sign-extended branch offset in words, from decode's `immed`.
- `imem_req`  out  1  read request, held until ack.
- `imem_addr`  out  32  read address, equals `pc` while `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  registered instruction to decode.
- `instr_valid`  out  1  `instr` holds a fetched, unconsumed word.
- `pc`  out  32  current PC (address of `instr` when valid).
- `fetch_err`  out  1  sticky handshake-timeout flag.

## Operation
- FSM states: IDLE, FETCH, HOLD, ERR. `imem_req` = (state==FETCH), decoded from state. `imem_addr` = `pc`.
- IDLE: entered on reset. `fetch_en`=1 → FETCH. `pc` is not changed.
- FETCH: `wait_cnt` increments each cycle without ack.
  - `imem_ack`=1 → `instr`<=`imem_rdata`, `instr_valid`<=1, `wait_cnt`<=0, go to HOLD.
  - No ack and `wait_cnt`==TIMEOUT-1 → ERR. An ack is therefore accepted in any of the first TIMEOUT FETCH cycles.
- HOLD: `instr` and `pc` stay stable. On `fetch_en`=1:
  - `pc` <= next PC, using `pc_sel`/`pc_immed` sampled in that cycle.
  - `instr_valid`<=0.
  - Go to FETCH.
- ERR: `imem_req`=0, `instr_valid`=0, `fetch_err`=1. Stays in ERR until reset.
- `imem_ack` outside FETCH is ignored. `fetch_en` in FETCH or ERR is ignored.
- Arithmetic: 32-bit, modulo 2^32 wrap. The shift discards `pc_immed[31:30]`. `pc[1:0]` is always 00 when RESET_PC is aligned.
- Reset (any state, including mid-handshake):
  - `pc`=RESET_PC, `instr`=0, `instr_valid`=0, `fetch_err`=0, `wait_cnt`=0, state IDLE.
  - `imem_req` drops immediately (asynchronous). A late ack after reset is ignored.

## Timing
- Ack in the first FETCH cycle → `instr_valid`=1 on the following cycle.
- Zero-wait throughput: one instruction per 2 cycles (FETCH + HOLD), with `fetch_en` held high.
- The new PC appears on `imem_addr` in the cycle after `fetch_en` is sampled in HOLD.
- `instr_valid` falls in the same edge that updates `pc`.
- Each wait state adds 1 cycle of latency.
- `fetch_err` rises on the edge that ends the TIMEOUT-th unacked FETCH cycle.

## Test plan
- Reset with RESET_PC=0: all outputs 0, `imem_req`=0. Assert `fetch_en` with ack in the same cycle → `imem_addr` sequence 0x0, 0x4, 0x8. Each `instr` matches memory, and `instr_valid` pulses 1 cycle high, 1 cycle low.
- Branch: in HOLD at pc=0x8, set `pc_sel`=1, `pc_immed`=0xFFFF_FFFE, `fetch_en`=1 → next `imem_addr`=0x4. With `pc_immed`=0x3 → next `imem_addr`=0x18.
- Wait states: ack delayed 3 cycles → `imem_req`/`imem_addr` stable for 4 cycles, `instr_valid` rises on the cycle after the ack, `fetch_err`=0.
- Timeout (TIMEOUT=16): no ack for 16 cycles → `fetch_err`=1, `imem_req`=0. A later ack and `fetch_en` have no effect until reset clears `fetch_err`.
- Reset mid-FETCH after 2 wait cycles: `imem_req` drops asynchronously, state returns to IDLE. An ack arriving the next cycle does not set `instr_valid`.
- Wrap-around: RESET_PC=0xFFFF_FFFC, sequential advance → next `imem_addr`=0x0000_0000.
